dma_ctrl: RTL and testbench



---
 rtl/dma_ctrl_if.sv | 27 ++
 rtl/dma_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dma_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_ctrl_if
// Brief    : MMIO slot port plus memory master port of the block-copy DMA.
// Revision : 1.0
// ============================================================================
interface dma_ctrl_if;
   logic [2:0]  rs;
   logic        we;
   logic        en;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        rdy;
   logic        bus_own;
   logic [15:0] m_addr;
   logic        m_we;
   logic [7:0]  m_wdata;
   logic [7:0]  m_rdata;
   logic        irq;

   // slave: the DMA block itself; master: the slot controller / system side
   modport slave  (input  rs, we, en, din, m_rdata,
                   output dout, rdy, bus_own, m_addr, m_we, m_wdata, irq);
   modport master (output rs, we, en, din, m_rdata,
                   input  dout, rdy, bus_own, m_addr, m_we, m_wdata, irq);
endinterface
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_ctrl
// Brief    : Memory-to-memory block copy engine; stalls the CPU via RDY while
//            it owns the shared bus.
// Revision : 1.0
// ============================================================================
module dma_ctrl #(
   parameter int GRANT_DELAY = 1,
   parameter int RD_LATENCY  = 1
) (
   input  logic       clk,
   input  logic       rst,
   dma_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STALL = 3'd1,
      S_RD    = 3'd2,
      S_WAIT  = 3'd3,
      S_WR    = 3'd4
   } state_t;

   localparam logic [2:0] c_grant_init = 3'(GRANT_DELAY - 1);
   localparam logic [2:0] c_wait_init  = 3'(RD_LATENCY - 1);

   state_t      r_state;
   logic [15:0] r_src;
   logic [15:0] r_dst;
   logic [15:0] r_len;
   logic [2:0]  r_cnt;
   logic        r_done;
   logic        r_irq_en;
   logic        r_rdy;
   logic        r_bus_own;
   logic [15:0] r_m_addr;
   logic        r_m_we;
   logic [7:0]  r_m_wdata;

   logic        w_wr;
   logic        w_busy;
   logic [15:0] w_src_nxt;
   logic [15:0] w_dst_nxt;
   logic [15:0] w_len_nxt;

   assign w_wr      = bus.en & bus.we;
   assign w_busy    = (r_state != S_IDLE);
   assign w_src_nxt = r_src + 16'd1;
   assign w_dst_nxt = r_dst + 16'd1;
   assign w_len_nxt = r_len - 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_src     <= 16'd0;
         r_dst     <= 16'd0;
         r_len     <= 16'd0;
         r_cnt     <= 3'd0;
         r_done    <= 1'b0;
         r_irq_en  <= 1'b0;
         r_rdy     <= 1'b1;
         r_bus_own <= 1'b0;
         r_m_addr  <= 16'd0;
         r_m_we    <= 1'b0;
         r_m_wdata <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_wr) begin
                  case (bus.rs)
                     3'd0: r_src[7:0]  <= bus.din;
                     3'd1: r_src[15:8] <= bus.din;
                     3'd2: r_dst[7:0]  <= bus.din;
                     3'd3: r_dst[15:8] <= bus.din;
                     3'd4: r_len[7:0]  <= bus.din;
                     3'd5: r_len[15:8] <= bus.din;
                     3'd6: begin
                        // irq_en is only taken from a start write; a bare
                        // clear-done write leaves it untouched
                        if (bus.din[0]) begin
                           r_irq_en <= bus.din[1];
                           if (r_len != 16'd0) begin
                              r_state <= S_STALL;
                              r_done  <= 1'b0;
                              r_rdy   <= 1'b0;
                              r_cnt   <= c_grant_init;
                           end else begin
                              r_done  <= 1'b1;
                           end
                        end else if (bus.din[7]) begin
                           r_done <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_STALL: begin
               if (r_cnt == 3'd0) begin
                  r_state   <= S_RD;
                  r_bus_own <= 1'b1;
                  r_m_addr  <= r_src;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_RD: begin
               r_state <= S_WAIT;
               r_cnt   <= c_wait_init;
            end
            S_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_state   <= S_WR;
                  r_m_addr  <= r_dst;
                  r_m_we    <= 1'b1;
                  r_m_wdata <= bus.m_rdata;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_WR: begin
               r_src  <= w_src_nxt;
               r_dst  <= w_dst_nxt;
               r_len  <= w_len_nxt;
               r_m_we <= 1'b0;
               if (w_len_nxt == 16'd0) begin
                  r_state   <= S_IDLE;
                  r_done    <= 1'b1;
                  r_rdy     <= 1'b1;
                  r_bus_own <= 1'b0;
                  r_m_addr  <= 16'd0;
                  r_m_wdata <= 8'd0;
               end else begin
                  r_state   <= S_RD;
                  r_m_addr  <= w_src_nxt;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.dout = 8'h00;
      case (bus.rs)
         3'd0: bus.dout = r_src[7:0];
         3'd1: bus.dout = r_src[15:8];
         3'd2: bus.dout = r_dst[7:0];
         3'd3: bus.dout = r_dst[15:8];
         3'd4: bus.dout = r_len[7:0];
         3'd5: bus.dout = r_len[15:8];
         3'd6: bus.dout = {r_done, 5'b00000, r_irq_en, w_busy};
         default: bus.dout = 8'h00;
      endcase
   end

   assign bus.rdy     = r_rdy;
   assign bus.bus_own = r_bus_own;
   assign bus.m_addr  = r_m_addr;
   assign bus.m_we    = r_m_we;
   assign bus.m_wdata = r_m_wdata;
   assign bus.irq     = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_ctrl
// Brief    : Self-checking bench for dma_ctrl against a byte-array copy model.
// Revision : 1.0
// ============================================================================
module tb_dma_ctrl;
   localparam int GD = 1;
   localparam int RL = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dma_ctrl_if bus ();

   dma_ctrl #(.GRANT_DELAY(GD), .RD_LATENCY(RL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // System RAM with one cycle of read latency
   logic [7:0] mem     [65536];
   logic [7:0] ref_mem [65536];

   always @(posedge clk) begin
      if (bus.bus_own && bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      bus.m_rdata <= mem[bus.m_addr];
   end

   // Expected bus traffic, filled by the copy model
   logic [23:0] wr_q [$];
   logic [15:0] rd_q [$];
   int          rdy_low;
   int          wr_cnt;
   bit          bus_seen;
   bit          prev_rd;
   bit          mon_rd;
   logic [23:0] mon_e;

   always @(negedge clk) begin
      if (!rst) begin
         if (!bus.rdy) rdy_low++;
         if (bus.bus_own) bus_seen = 1'b1;
         if (bus.m_we) begin
            wr_cnt++;
            if (wr_q.size() == 0) check("extra_write", 32'd1, 32'd0);
            else begin
               mon_e = wr_q.pop_front();
               check("wr_addr", {16'd0, bus.m_addr}, {16'd0, mon_e[23:8]});
               check("wr_data", {24'd0, bus.m_wdata}, {24'd0, mon_e[7:0]});
            end
         end
         mon_rd = bus.bus_own && !bus.m_we;
         if (mon_rd && !prev_rd) begin
            if (rd_q.size() == 0) check("extra_read", 32'd1, 32'd0);
            else check("rd_addr", {16'd0, bus.m_addr}, {16'd0, rd_q.pop_front()});
         end
         prev_rd = mon_rd;
      end
   end

   task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.rs = a; bus.din = d; bus.en = 1'b1; bus.we = 1'b1;
      @(negedge clk);
      bus.en = 1'b0; bus.we = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.rs = a; bus.en = 1'b1; bus.we = 1'b0;
      #1 d = bus.dout;
      bus.en = 1'b0;
   endtask

   // Model: strictly ascending byte copy with 16-bit wrap
   task automatic setup_copy(input logic [15:0] src, input logic [15:0] dst, input int len);
      logic [15:0] s, d;
      reg_write(3'd0, src[7:0]);  reg_write(3'd1, src[15:8]);
      reg_write(3'd2, dst[7:0]);  reg_write(3'd3, dst[15:8]);
      reg_write(3'd4, 8'(len));   reg_write(3'd5, 8'(len >> 8));
      for (int i = 0; i < len; i++) begin
         s = src + 16'(i);
         d = dst + 16'(i);
         ref_mem[d] = ref_mem[s];
         rd_q.push_back(s);
         wr_q.push_back({d, ref_mem[d]});
      end
      rdy_low = 0; wr_cnt = 0; bus_seen = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      bus.rs = 3'd6;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk); #1;
         if (bus.dout[0] == 1'b0) begin ok = 1'b1; break; end
      end
      check("idle_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic check_end(input int len);
      check("rdy_low_cycles", rdy_low, GD + len * (2 + RL));
      check("write_count", wr_cnt, len);
      check("wr_q_left", wr_q.size(), 0);
      check("rd_q_left", rd_q.size(), 0);
   endtask

   logic [7:0]  rd8;
   logic [15:0] r_src, r_dst;
   int          r_len;
   bit          r_ie;

   initial begin
      bus.rs = 3'd0; bus.we = 1'b0; bus.en = 1'b0; bus.din = 8'd0;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      #1;
      check("rst_rdy", {31'd0, bus.rdy}, 32'd1);
      check("rst_bus_own", {31'd0, bus.bus_own}, 32'd0);
      check("rst_m_addr", {16'd0, bus.m_addr}, 32'd0);
      check("rst_m_we", {31'd0, bus.m_we}, 32'd0);
      check("rst_irq", {31'd0, bus.irq}, 32'd0);
      for (int a = 0; a < 8; a++) begin
         reg_read(3'(a), rd8);
         check("rst_reg", {24'd0, rd8}, 32'd0);
      end

      // Register readback
      reg_write(3'd0, 8'h34); reg_write(3'd1, 8'h12);
      reg_write(3'd2, 8'hCD); reg_write(3'd3, 8'hAB);
      reg_write(3'd4, 8'h02); reg_write(3'd5, 8'h01);
      reg_write(3'd7, 8'hFF);
      reg_read(3'd0, rd8); check("rb_src_lo", {24'd0, rd8}, 32'h34);
      reg_read(3'd1, rd8); check("rb_src_hi", {24'd0, rd8}, 32'h12);
      reg_read(3'd2, rd8); check("rb_dst_lo", {24'd0, rd8}, 32'hCD);
      reg_read(3'd3, rd8); check("rb_dst_hi", {24'd0, rd8}, 32'hAB);
      reg_read(3'd4, rd8); check("rb_len_lo", {24'd0, rd8}, 32'h02);
      reg_read(3'd5, rd8); check("rb_len_hi", {24'd0, rd8}, 32'h01);
      reg_read(3'd7, rd8); check("rb_reg7", {24'd0, rd8}, 32'h00);

      // Directed 4-byte copy with irq enabled
      for (int i = 0; i < 4; i++) begin
         mem[16'h0200 + i]     = 8'(8'h11 * (i + 1));
         ref_mem[16'h0200 + i] = 8'(8'h11 * (i + 1));
      end
      setup_copy(16'h0200, 16'h0300, 4);
      reg_write(3'd6, 8'h03);
      wait_idle();
      check_end(4);
      check("rdy_13", rdy_low, 13);
      reg_read(3'd6, rd8); check("stat_done", {24'd0, rd8}, 32'h82);
      check("irq_set", {31'd0, bus.irq}, 32'd1);
      reg_write(3'd6, 8'h80);
      #1 check("irq_clr", {31'd0, bus.irq}, 32'd0);
      reg_read(3'd6, rd8); check("stat_clr", {24'd0, rd8}, 32'h02);

      // Zero-length start completes without bus activity
      reg_write(3'd4, 8'h00); reg_write(3'd5, 8'h00);
      rdy_low = 0; bus_seen = 1'b0;
      reg_write(3'd6, 8'h01);
      reg_read(3'd6, rd8); check("len0_stat", {24'd0, rd8}, 32'h80);
      repeat (5) @(negedge clk);
      check("len0_bus_own", {31'd0, bus_seen}, 32'd0);
      check("len0_rdy", rdy_low, 0);

      // Address wrap at 0xFFFF
      setup_copy(16'hFFFE, 16'h4000, 4);
      reg_write(3'd6, 8'h01);
      wait_idle();
      check_end(4);
      reg_read(3'd0, rd8); check("wrap_src_lo", {24'd0, rd8}, 32'h02);
      reg_read(3'd1, rd8); check("wrap_src_hi", {24'd0, rd8}, 32'h00);

      // Busy lockout: writes during a transfer are ignored
      setup_copy(16'h3000, 16'h5000, 8);
      reg_write(3'd6, 8'h01);
      reg_write(3'd2, 8'h55);
      reg_write(3'd6, 8'h01);
      wait_idle();
      check_end(8);
      reg_read(3'd2, rd8); check("lock_dst_lo", {24'd0, rd8}, 32'h08);
      reg_read(3'd3, rd8); check("lock_dst_hi", {24'd0, rd8}, 32'h50);

      // Randomized copies, overlap allowed
      for (int t = 0; t < 10; t++) begin
         r_src = 16'($urandom);
         r_dst = (t % 3 == 0) ? r_src + 16'($urandom_range(1, 4)) : 16'($urandom);
         r_len = $urandom_range(1, 12);
         r_ie  = 1'($urandom);
         setup_copy(r_src, r_dst, r_len);
         reg_write(3'd6, {6'd0, r_ie, 1'b1});
         wait_idle();
         check_end(r_len);
         reg_read(3'd6, rd8); check("rnd_stat", {24'd0, rd8}, {24'd0, 1'b1, 5'd0, r_ie, 1'b0});
         check("rnd_irq", {31'd0, bus.irq}, {31'd0, r_ie});
         reg_read(3'd0, rd8); check("rnd_src_lo", {24'd0, rd8}, {24'd0, 8'(r_src + 16'(r_len))});
         reg_read(3'd4, rd8); check("rnd_len_lo", {24'd0, rd8}, 32'd0);
      end

      // Reset in the WAIT of byte 2 aborts with exactly one write done
      setup_copy(16'h1000, 16'h2000, 8);
      reg_write(3'd6, 8'h03);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk); #1;
         if (bus.m_we) break;
      end
      @(negedge clk); #1;
      check("abort_rd", {31'd0, bus.bus_own && !bus.m_we}, 32'd1);
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      check("abort_rdy", {31'd0, bus.rdy}, 32'd1);
      check("abort_bus_own", {31'd0, bus.bus_own}, 32'd0);
      check("abort_m_we", {31'd0, bus.m_we}, 32'd0);
      check("abort_irq", {31'd0, bus.irq}, 32'd0);
      for (int a = 0; a < 7; a++) begin
         reg_read(3'(a), rd8);
         check("abort_reg", {24'd0, rd8}, 32'd0);
      end
      repeat (10) @(negedge clk);
      check("abort_writes", wr_cnt, 1);
      wr_q.delete();
      rd_q.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
